// File: rtl/calc_sequencer_pkg.sv
// Shared opcodes, FSM encoding and iteration count for the calculator sequencer.
package calc_sequencer_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  localparam int MUL_ITER = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MUL  = 2'b10
  } state_t;

endpackage

// File: rtl/somador_8bits.sv
// 8-bit ripple-carry adder; purely combinational.
module somador_8bits (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] s_o,
  output logic       cout_o
);

  logic [8:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[8];

endmodule

// File: rtl/calc_sequencer.sv
// Operand/sequencing stage around one shared 8-bit adder: add/sub done 2 edges after start, multiply 9.
// No backpressure: start is taken only while ready, ignored while busy; results hold until the next done.
module calc_sequencer
  import calc_sequencer_pkg::*;
#(
  parameter bit MUL_ENABLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [7:0] result_hi,
  output logic       carry,
  output logic       overflow,
  output logic       zero
);

  localparam logic [3:0] MUL_LAST = 4'(MUL_ITER - 1);

  state_t     state_q, state_d;
  logic [7:0] a_q, b_q;
  logic [1:0] op_q;
  logic [7:0] p_hi_q, p_lo_q;
  logic [3:0] cnt_q;
  logic [7:0] result_q, result_hi_q;
  logic       carry_q, overflow_q, zero_q, done_q;

  logic [7:0] add_a, add_b, add_s;
  logic       add_cin, add_cout;
  logic [7:0] prod_hi_d, prod_lo_d;
  logic       mul_last;

  somador_8bits u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .s_o    (add_s),
    .cout_o (add_cout)
  );

  // In MUL the adder accumulates the multiplicand into P_hi; otherwise it serves add/sub.
  always_comb begin
    add_a   = a_q;
    add_b   = b_q;
    add_cin = 1'b0;
    if (state_q == MUL) begin
      add_a = p_hi_q;
      add_b = p_lo_q[0] ? a_q : 8'h00;
    end else if (op_q == OP_SUB) begin
      add_b   = ~b_q;
      add_cin = 1'b1;
    end
  end

  assign prod_hi_d = {add_cout, add_s[7:1]};
  assign prod_lo_d = {add_s[0], p_lo_q[7:1]};
  assign mul_last  = (cnt_q == MUL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (op == OP_MUL && MUL_ENABLE) ? MUL : EXEC;
      EXEC:    state_d = IDLE;
      MUL:     if (mul_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == IDLE);
    busy  = (state_q == EXEC) || (state_q == MUL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      op_q        <= OP_ADD;
      p_hi_q      <= 8'h00;
      p_lo_q      <= 8'h00;
      cnt_q       <= 4'd0;
      result_q    <= 8'h00;
      result_hi_q <= 8'h00;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q    <= a_in;
            b_q    <= b_in;
            op_q   <= op;
            p_hi_q <= 8'h00;
            p_lo_q <= b_in;
            cnt_q  <= 4'd0;
          end
        end
        EXEC: begin
          done_q      <= 1'b1;
          result_hi_q <= 8'h00;
          // A disabled multiply opcode lands here and falls into the clear branch.
          if (op_q == OP_ADD || op_q == OP_SUB) begin
            result_q   <= add_s;
            carry_q    <= add_cout;
            zero_q     <= (add_s == 8'h00);
            overflow_q <= (op_q == OP_ADD) ? ((a_q[7] == b_q[7]) && (add_s[7] != a_q[7]))
                                           : ((a_q[7] != b_q[7]) && (add_s[7] != a_q[7]));
          end else begin
            result_q   <= 8'h00;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b1;
          end
        end
        MUL: begin
          p_hi_q <= prod_hi_d;
          p_lo_q <= prod_lo_d;
          cnt_q  <= cnt_q + 4'd1;
          if (mul_last) begin
            done_q      <= 1'b1;
            result_q    <= prod_lo_d;
            result_hi_q <= prod_hi_d;
            carry_q     <= 1'b0;
            overflow_q  <= (prod_hi_d != 8'h00);
            zero_q      <= ({prod_hi_d, prod_lo_d} == 16'h0000);
          end
        end
        default: ;
      endcase
    end
  end

  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: stimulus queues expected results, a negedge monitor checks each done.
module tb_calc_sequencer;
  import calc_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [7:0] a_in, b_in;
  logic       ready, busy, done;
  logic [7:0] result, result_hi;
  logic       carry, overflow, zero;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] rh;
    logic       c;
    logic       v;
    logic       z;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  calc_sequencer #(.MUL_ENABLE(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] r, input logic [7:0] rh,
                              input logic c, input logic v, input logic z);
    exp_t e;
    e.r = r; e.rh = rh; e.c = c; e.v = v; e.z = z;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t  e;
    string n;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 with result=0x%0h, expected no done", result);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        chk({n, ".result"},    16'(result),    16'(e.r));
        chk({n, ".result_hi"}, 16'(result_hi), 16'(e.rh));
        chk({n, ".carry"},     16'(carry),     16'(e.c));
        chk({n, ".overflow"},  16'(overflow),  16'(e.v));
        chk({n, ".zero"},      16'(zero),      16'(e.z));
      end
    end
  end

  task automatic check_reset(input string n);
    chk({n, ".ready"},     16'(ready),     16'd1);
    chk({n, ".busy"},      16'(busy),      16'd0);
    chk({n, ".done"},      16'(done),      16'd0);
    chk({n, ".result"},    16'(result),    16'd0);
    chk({n, ".result_hi"}, 16'(result_hi), 16'd0);
    chk({n, ".carry"},     16'(carry),     16'd0);
    chk({n, ".overflow"},  16'(overflow),  16'd0);
    chk({n, ".zero"},      16'(zero),      16'd1);
  endtask

  // Drives a request and returns 1 time unit after the accepting edge.
  task automatic launch(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input string n, input bit push, input exp_t e);
    if (push) begin
      exp_q.push_back(e);
      name_q.push_back(n);
    end
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges from the accepting edge (edge 1) until done is seen; returns in the done cycle.
  task automatic wait_done(input string n, input int lat, input bit inject);
    int edges = 1;
    bit seen  = 1'b0;
    while (!seen && edges < 30) begin
      @(posedge clk);
      edges++;
      #1;
      if (inject && edges == 4) begin
        start = 1'b1;
        op    = OP_ADD;
        a_in  = 8'd1;
        b_in  = 8'd1;
      end
      if (inject && edges == 5) start = 1'b0;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: got no done within 30 edges, expected done after %0d", n, lat);
    end else begin
      chk({n, ".latency"},    16'(edges), 16'(lat));
      chk({n, ".ready_done"}, 16'(ready), 16'd1);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = OP_ADD;
    a_in  = 8'd0;
    b_in  = 8'd0;
    #12;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Add/sub chain, each new start issued in the previous done cycle.
    launch(OP_ADD, 8'd100, 8'd27, "add_100_27", 1'b1, mk(8'd127, 8'd0, 1'b0, 1'b0, 1'b0));
    wait_done("add_100_27", 2, 1'b0);
    launch(OP_ADD, 8'd200, 8'd100, "add_200_100", 1'b1, mk(8'd44, 8'd0, 1'b1, 1'b0, 1'b0));
    wait_done("add_200_100", 2, 1'b0);
    launch(OP_ADD, 8'd100, 8'd50, "add_100_50", 1'b1, mk(8'd150, 8'd0, 1'b0, 1'b1, 1'b0));
    wait_done("add_100_50", 2, 1'b0);
    launch(OP_SUB, 8'd5, 8'd7, "sub_5_7", 1'b1, mk(8'd254, 8'd0, 1'b0, 1'b0, 1'b0));
    wait_done("sub_5_7", 2, 1'b0);
    launch(OP_SUB, 8'd9, 8'd9, "sub_9_9", 1'b1, mk(8'd0, 8'd0, 1'b1, 1'b0, 1'b1));
    wait_done("sub_9_9", 2, 1'b0);
    @(negedge clk);

    // Multiply with a stray start while busy; the stray must not be accepted.
    launch(OP_MUL, 8'd13, 8'd11, "mul_13_11", 1'b1, mk(8'd143, 8'd0, 1'b0, 1'b0, 1'b0));
    wait_done("mul_13_11", 9, 1'b1);
    repeat (3) @(negedge clk);
    chk("hold.result",    16'(result),    16'd143);
    chk("hold.result_hi", 16'(result_hi), 16'd0);
    chk("hold.ready",     16'(ready),     16'd1);

    launch(OP_MUL, 8'd255, 8'd255, "mul_255_255", 1'b1, mk(8'h01, 8'hFE, 1'b0, 1'b1, 1'b0));
    wait_done("mul_255_255", 9, 1'b0);
    launch(OP_CLR, 8'd7, 8'd7, "clear", 1'b1, mk(8'd0, 8'd0, 1'b0, 1'b0, 1'b1));
    wait_done("clear", 2, 1'b0);
    launch(OP_MUL, 8'd0, 8'd5, "mul_0_5", 1'b1, mk(8'd0, 8'd0, 1'b0, 1'b0, 1'b1));
    wait_done("mul_0_5", 9, 1'b0);
    @(negedge clk);

    // Reset after the fourth multiply iteration: no done, product discarded.
    launch(OP_MUL, 8'd255, 8'd3, "mul_rst", 1'b0, mk(8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
    repeat (3) @(posedge clk);
    #1;
    chk("mid_mul.busy", 16'(busy), 16'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset("mid_mul_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    launch(OP_ADD, 8'd3, 8'd4, "add_3_4", 1'b1, mk(8'd7, 8'd0, 1'b0, 1'b0, 1'b0));
    wait_done("add_3_4", 2, 1'b0);

    repeat (2) @(negedge clk);
    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
